multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL use one clock and an asynchronously asserted, active-low reset; ports:
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction bits 31:26, taken from the instruction register.
REQ-005 funct  input  6  instruction bits 5:0.
REQ-006 zf  input  1  ALU zero flag.
REQ-007 alu_sel  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-008 alu_src_a  output  1  0=PC, 1=register A.
REQ-009 alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en  output  1 each  standard multicycle datapath controls.
REQ-012 illegal  output  1  sticky illegal-instruction flag (REQ-030).

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, TRAP; one transition per clk.
REQ-014 FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_sel=010, pc_src=00, pc_en=1; next is DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_sel=010; next by opcode: 100011/101011 MEMADR, 000000 EXECUTE, 000100 BRANCH, 001000 ADDIEXEC, 000010 JUMP, other = illegal.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_sel=010; next is MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: iord=1; next is MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next is FETCH.
REQ-018 MEMWR: iord=1, mem_write=1; next is FETCH.
REQ-019 EXECUTE: alu_src_a=1, alu_src_b=00, alu_sel from funct (100100 and, 100101 or, 100000 add, 100010 sub, 101010 slt; other funct = illegal); next is ALUWB.
REQ-020 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next is FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=110, pc_src=01, pc_en=zf (only combinational input path); next is FETCH.
REQ-022 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_sel=010; next is ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next is FETCH.
REQ-023 JUMP: pc_src=10, pc_en=1; next is FETCH.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 Latencies in cycles from FETCH to FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
REQ-026 opcode/funct SHALL be sampled only in DECODE/EXECUTE; changes in other states SHALL be ignored.
REQ-027 An unreachable state encoding SHALL transition to FETCH.

Reset
REQ-028 rst_n low SHALL force the state to FETCH immediately; ir_write, mem_write, reg_write and pc_en SHALL be 0 while rst_n is low; illegal SHALL be 0.
REQ-029 Reset asserted mid-instruction SHALL abort it; the first rising clk after deassertion SHALL perform FETCH.

Configuration
REQ-030 With ILLEGAL_TRAP_EN defined: an illegal opcode/funct SHALL enter TRAP (all enables 0, illegal=1), where the FSM holds until reset.
REQ-031 Without ILLEGAL_TRAP_EN: an illegal instruction SHALL return to FETCH as a NOP with no write; illegal SHALL be tied to 0 and there is no TRAP state.

Structure
REQ-032 A shared package SHALL hold the state encoding, opcode and funct constants, and the alu_sel codes.
REQ-033 Funct-to-alu_sel decoding SHALL be a sub-module named alu_decoder (combinational, with an illegal-funct output).

Verification
REQ-034 opcode=000000, funct=101010 -> FETCH,DECODE,EXECUTE(alu_sel=111),ALUWB(reg_write=1,reg_dst=1); back at FETCH in cycle 5.
REQ-035 lw opcode=100011 -> 5 states; MEMRD iord=1; MEMWB mem_to_reg=1, reg_write=1; sw 101011 -> MEMWR mem_write=1 in cycle 4.
REQ-036 beq 000100, zf=1 -> BRANCH pc_en=1, pc_src=01; repeat with zf=0 -> pc_en=0; both return to FETCH in cycle 4.
REQ-037 opcode=111111: with ILLEGAL_TRAP_EN -> TRAP, illegal=1 held for 10 cycles; without it -> FETCH in cycle 3, no write enable asserted.
REQ-038 rst_n pulsed low during MEMWB -> reg_write drops immediately; after release, FETCH with ir_write=1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcode/funct constants, ALU codes, per-state controls.
// ILLEGAL_TRAP_EN adds the TRAP state used to park the FSM on an illegal instruction.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
`ifdef ILLEGAL_TRAP_EN
      , S_TRAP   = 4'd12
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic [2:0] alu_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic       iord;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       pc_en;
   } ctrl_t;

   // Moore outputs of a state; rsel only matters for EXECUTE. Unlisted fields stay 0.
   function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] rsel);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_sel   = ALU_ADD;
            c.pc_en     = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.alu_sel   = ALU_ADD;
         end
         S_MEMADR, S_ADDIEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_sel   = ALU_ADD;
         end
         S_MEMRD: c.iord = 1'b1;
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_sel   = rsel;
         end
         S_ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_sel   = ALU_SUB;
            c.pc_src    = 2'b01;
         end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JUMP: begin
            c.pc_src = 2'b10;
            c.pc_en  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational funct -> alu_sel decode with an illegal-funct flag; zero latency, no flow control.
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_sel,
   output logic       illegal
);

   always_comb begin
      alu_sel = ALU_ADD;
      illegal = 1'b0;
      case (funct)
         FN_AND:  alu_sel = ALU_AND;
         FN_OR:   alu_sel = ALU_OR;
         FN_ADD:  alu_sel = ALU_ADD;
         FN_SUB:  alu_sel = ALU_SUB;
         FN_SLT:  alu_sel = ALU_SLT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-subset datapath; outputs registered, one state per clk, no backpressure.
// ILLEGAL_TRAP_EN: illegal opcode/funct parks in TRAP with sticky illegal=1 until reset; otherwise it retires as a NOP.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zf,
   output logic [2:0] alu_sel,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       pc_en,
   output logic       illegal
);

`ifdef ILLEGAL_TRAP_EN
   localparam state_t ILL_NXT = S_TRAP;
`else
   localparam state_t ILL_NXT = S_FETCH;
`endif

   state_t     state, nxt;
   ctrl_t      ctl;
   logic       is_sw, funct_bad;
   logic [2:0] dec_sel;
   logic       dec_bad;

   alu_decoder u_alu_decoder (
      .funct   (funct),
      .alu_sel (dec_sel),
      .illegal (dec_bad)
   );

   always_comb begin
      nxt = S_FETCH;
      case (state)
         S_FETCH: nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_EXECUTE;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI:      nxt = S_ADDIEXEC;
               OP_J:         nxt = S_JUMP;
               default:      nxt = ILL_NXT;
            endcase
         end
         S_MEMADR:   nxt = is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:    nxt = S_MEMWB;
         S_EXECUTE:  nxt = funct_bad ? ILL_NXT : S_ALUWB;
         S_ADDIEXEC: nxt = S_ADDIWB;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:     nxt = S_TRAP;
`endif
         default:    nxt = S_FETCH;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
`endif

   // lw/sw and the funct verdict are captured in DECODE so the instruction bits can move afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         ctl       <= state_ctrl(S_FETCH, ALU_ADD);
         is_sw     <= 1'b0;
         funct_bad <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state <= nxt;
         ctl   <= state_ctrl(nxt, dec_sel);
         if (state == S_DECODE) begin
            is_sw     <= (opcode == OP_SW);
            funct_bad <= dec_bad;
         end
`ifdef ILLEGAL_TRAP_EN
         if (nxt == S_TRAP) illegal_q <= 1'b1;
`endif
      end
   end

`ifdef ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign alu_sel    = ctl.alu_sel;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign pc_src     = ctl.pc_src;
   assign iord       = ctl.iord;
   assign reg_dst    = ctl.reg_dst;
   assign mem_to_reg = ctl.mem_to_reg;
   // Enables are masked by rst_n so the FETCH reset image cannot write while reset is held.
   assign ir_write   = ctl.ir_write  & rst_n;
   assign mem_write  = ctl.mem_write & rst_n;
   assign reg_write  = ctl.reg_write & rst_n;
   assign pc_en      = (ctl.pc_en | ((state == S_BRANCH) & zf)) & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle control vectors against a per-instruction reference table.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zf = 1'b0;
   logic [2:0] alu_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zf(zf),
      .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .iord(iord), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_en(pc_en), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {alu_sel, alu_src_a, alu_src_b, pc_src, iord, ir_write, mem_write,
                 reg_write, reg_dst, mem_to_reg, pc_en, illegal};

   int n_total = 0;
   int n_pass  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] msk_q[$];

   function automatic logic [15:0] cv(input logic [2:0] s, input logic a, input logic [1:0] b,
                                      input logic [1:0] p, input logic io, input logic irw,
                                      input logic mw, input logic rw, input logic rd,
                                      input logic m2r, input logic pe, input logic il);
      return {s, a, b, p, io, irw, mw, rw, rd, m2r, pe, il};
   endfunction

   function automatic logic legal_fn(input logic [5:0] fn);
      return fn == 6'b100100 || fn == 6'b100101 || fn == 6'b100000 ||
             fn == 6'b100010 || fn == 6'b101010;
   endfunction

   function automatic logic [2:0] fn_sel(input logic [5:0] fn);
      case (fn)
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         default:   return 3'b111;
      endcase
   endfunction

   function automatic logic legal_op(input logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   task automatic push(input logic [15:0] v, input logic [15:0] m);
      exp_q.push_back(v);
      msk_q.push_back(m);
   endtask

   task automatic ill_tail();
`ifdef ILLEGAL_TRAP_EN
      repeat (10) push(cv(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1), 16'hFFFF);
`else
      push(cv(3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0), 16'hFFFF);
`endif
   endtask

   // Expected control vector for every cycle of one instruction, ending at the following FETCH.
   task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      logic [15:0] f;
      f = cv(3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
      push(f, 16'hFFFF);
      push(cv(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
      case (op)
         6'b100011: begin
            push(cv(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
            push(cv(3'b000, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
            push(cv(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0), 16'hFFFF);
            push(f, 16'hFFFF);
         end
         6'b101011: begin
            push(cv(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
            push(cv(3'b000, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0), 16'hFFFF);
            push(f, 16'hFFFF);
         end
         6'b000000: begin
            if (legal_fn(fn)) begin
               push(cv(fn_sel(fn), 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
               push(cv(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0), 16'hFFFF);
               push(f, 16'hFFFF);
            end else begin
               push(cv(3'b000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'h1FFF);
               ill_tail();
            end
         end
         6'b000100: begin
            push(cv(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, z, 0), 16'hFFFF);
            push(f, 16'hFFFF);
         end
         6'b001000: begin
            push(cv(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 16'hFFFF);
            push(cv(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0), 16'hFFFF);
            push(f, 16'hFFFF);
         end
         6'b000010: begin
            push(cv(3'b000, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0), 16'hFFFF);
            push(f, 16'hFFFF);
         end
         default: ill_tail();
      endcase
   endtask

   // Entered shortly after a negedge with the DUT in FETCH; instruction bits are scrambled once past DECODE/EXECUTE.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
      int n;
      exp_q.delete();
      msk_q.delete();
      model_instr(op, fn, z);
      n = exp_q.size();
      opcode = op;
      funct  = fn;
      zf     = z;
      for (int i = 0; i < n; i++) begin
         if (i >= 3 && i < n - 1) begin
            opcode = 6'($urandom_range(63));
            funct  = 6'($urandom_range(63));
         end
         #1;
         n_total++;
         if ((obs & msk_q[i]) !== (exp_q[i] & msk_q[i]))
            $display("FAIL %s cycle %0d: got %h want %h (mask %h)", name, i + 1, obs, exp_q[i], msk_q[i]);
         else
            n_pass++;
         if (i < n - 1) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_total++;
      if ({ir_write, mem_write, reg_write, pc_en, illegal} !== 5'b0)
         $display("FAIL reset_enables: got %b want 00000", {ir_write, mem_write, reg_write, pc_en, illegal});
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if ({ir_write, mem_write, reg_write, pc_en, illegal} !== 5'b0)
         $display("FAIL reset_held: got %b want 00000", {ir_write, mem_write, reg_write, pc_en, illegal});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      run_instr("rtype_slt", 6'b000000, 6'b101010, 1'b0);
      run_instr("rtype_and", 6'b000000, 6'b100100, 1'b1);
      run_instr("rtype_sub", 6'b000000, 6'b100010, 1'b0);
   endtask

   task automatic test_mem();
      run_instr("lw", 6'b100011, 6'd0, 1'b0);
      run_instr("sw", 6'b101011, 6'd17, 1'b1);
   endtask

   task automatic test_branch_jump();
      run_instr("beq_taken", 6'b000100, 6'd5, 1'b1);
      run_instr("beq_not_taken", 6'b000100, 6'd5, 1'b0);
      run_instr("addi", 6'b001000, 6'd9, 1'b0);
      run_instr("j", 6'b000010, 6'd3, 1'b1);
   endtask

   task automatic test_illegal();
      run_instr("illegal_op", 6'b111111, 6'd0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      do_reset();
`endif
      run_instr("illegal_funct", 6'b000000, 6'b111111, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      do_reset();
`endif
      run_instr("after_illegal", 6'b000000, 6'b100101, 1'b0);
   endtask

   task automatic test_reset_mid();
      opcode = 6'b100011;
      funct  = 6'd0;
      repeat (4) @(negedge clk);
      #1;
      n_total++;
      if (reg_write !== 1'b1) $display("FAIL memwb_reg_write: got %b want 1", reg_write);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({ir_write, mem_write, reg_write, pc_en} !== 4'b0)
         $display("FAIL mid_reset_enables: got %b want 0000", {ir_write, mem_write, reg_write, pc_en});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++;
      if (obs !== cv(3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0))
         $display("FAIL post_reset_fetch: got %h want FETCH vector", obs);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (obs !== cv(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0))
         $display("FAIL post_reset_decode: got %h want DECODE vector", obs);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
      int kind, maxk;
`ifdef ILLEGAL_TRAP_EN
      maxk = 5;
`else
      maxk = 7;
`endif
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(maxk);
         fn   = 6'($urandom_range(63));
         case (kind)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000100;
            3: op = 6'b001000;
            4: op = 6'b000010;
            5: begin
               op = 6'b000000;
               case ($urandom_range(4))
                  0: fn = 6'b100100;
                  1: fn = 6'b100101;
                  2: fn = 6'b100000;
                  3: fn = 6'b100010;
                  default: fn = 6'b101010;
               endcase
            end
            6: begin
               op = 6'($urandom_range(63));
               while (legal_op(op)) op = 6'($urandom_range(63));
            end
            default: begin
               op = 6'b000000;
               while (legal_fn(fn)) fn = 6'($urandom_range(63));
            end
         endcase
         run_instr("random", op, fn, 1'($urandom_range(1)));
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_mem();
      test_branch_jump();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
